// File: rtl/cache_tag_engine.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_engine
// Brief    : N-way set-associative tag / true-LRU replacement engine with
//            saturating hit/miss statistics. Optional per-line dirty tracking
//            is enabled by defining CACHE_WB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_tag_engine #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 4,
    parameter int CNT_W    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic                               req_we,
    input  logic                               flush,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic                               resp_hit,
    output logic [$clog2(WAYS)-1:0]            resp_way,
    output logic                               resp_evict_valid,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] resp_evict_tag,
    output logic                               resp_evict_dirty,
    output logic [CNT_W-1:0]                   hit_cnt,
    output logic [CNT_W-1:0]                   miss_cnt
);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int NUM_SETS = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_UPDATE = 3'd2,
        S_RESP   = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_req_tag;
    logic               r_hit;
    logic [WAY_W-1:0]   r_way;
    logic               r_flush_pend;
    logic [INDEX_W-1:0] r_flush_idx;
    logic [WAYS-1:0]    r_valid [NUM_SETS];
    logic [TAG_W-1:0]   r_tags  [NUM_SETS][WAYS];
    logic [WAY_W-1:0]   r_age   [NUM_SETS][WAYS];
    logic               r_resp_hit;
    logic [WAY_W-1:0]   r_resp_way;
    logic               r_evict_valid;
    logic [TAG_W-1:0]   r_evict_tag;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               w_lookup_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_flush_go;
    logic               w_accept;

    // A flush seen in IDLE (or one latched earlier) takes priority over a request.
    assign w_flush_go = flush || r_flush_pend;
    assign req_ready  = (r_state == S_IDLE) && !w_flush_go;
    assign w_accept   = req_valid && req_ready;

    always_comb begin
        w_lookup_hit = 1'b0;
        w_hit_way    = '0;
        w_victim     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[r_index][w] && (r_tags[r_index][w] == r_req_tag)) begin
                w_lookup_hit = 1'b1;
                w_hit_way    = WAY_W'(w);
            end
        end
        // Oldest way is the fallback; the descending scan then lets the
        // lowest-index invalid way override it.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_age[r_index][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[r_index][w]) w_victim = WAY_W'(w);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_flush_go)     w_next_state = S_FLUSH;
                else if (req_valid) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = S_RESP;
            S_RESP:   if (resp_ready) w_next_state = S_IDLE;
            S_FLUSH:  if (r_flush_idx == INDEX_W'(NUM_SETS - 1)) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_req_tag     <= '0;
            r_hit         <= 1'b0;
            r_way         <= '0;
            r_flush_pend  <= 1'b0;
            r_flush_idx   <= '0;
            r_resp_hit    <= 1'b0;
            r_resp_way    <= '0;
            r_evict_valid <= 1'b0;
            r_evict_tag   <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tags[s][w] <= '0;
                    r_age[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            r_state <= w_next_state;
            // IDLE always services a pending flush, so leaving IDLE clears it.
            if (r_state == S_IDLE) r_flush_pend <= 1'b0;
            else if (flush)        r_flush_pend <= 1'b1;
            if (w_accept) begin
                r_index   <= req_addr[OFFSET_W +: INDEX_W];
                r_req_tag <= req_addr[ADDR_W-1 -: TAG_W];
            end
            case (r_state)
                S_LOOKUP: begin
                    r_hit <= w_lookup_hit;
                    r_way <= w_lookup_hit ? w_hit_way : w_victim;
                end
                S_UPDATE: begin
                    r_resp_hit <= r_hit;
                    r_resp_way <= r_way;
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == r_way)
                            r_age[r_index][w] <= '0;
                        else if (r_age[r_index][w] < r_age[r_index][r_way])
                            r_age[r_index][w] <= r_age[r_index][w] + 1'b1;
                    end
                    if (r_hit) begin
                        r_evict_valid <= 1'b0;
                        r_evict_tag   <= '0;
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else begin
                        r_evict_valid           <= r_valid[r_index][r_way];
                        r_evict_tag             <= r_valid[r_index][r_way] ? r_tags[r_index][r_way] : '0;
                        r_tags[r_index][r_way]  <= r_req_tag;
                        r_valid[r_index][r_way] <= 1'b1;
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_flush_idx] <= '0;
                    r_flush_idx          <= r_flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_WB_EN
    logic            r_we;
    logic            r_evict_dirty;
    logic [WAYS-1:0] r_dirty [NUM_SETS];
    logic            w_unused_bits;

    assign w_unused_bits    = ^req_addr[OFFSET_W-1:0];
    assign resp_evict_dirty = r_evict_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_evict_dirty <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) r_dirty[s] <= '0;
        end else begin
            if (w_accept) r_we <= req_we;
            if (r_state == S_UPDATE) begin
                if (r_hit) begin
                    r_evict_dirty <= 1'b0;
                    if (r_we) r_dirty[r_index][r_way] <= 1'b1;
                end else begin
                    r_evict_dirty           <= r_valid[r_index][r_way] && r_dirty[r_index][r_way];
                    r_dirty[r_index][r_way] <= r_we;
                end
            end else if (r_state == S_FLUSH) begin
                r_dirty[r_flush_idx] <= '0;
            end
        end
    end
`else
    logic w_unused_bits;

    assign w_unused_bits    = ^{req_addr[OFFSET_W-1:0], req_we};
    assign resp_evict_dirty = 1'b0;
`endif

    assign resp_valid       = (r_state == S_RESP);
    assign resp_hit         = r_resp_hit;
    assign resp_way         = r_resp_way;
    assign resp_evict_valid = r_evict_valid;
    assign resp_evict_tag   = r_evict_tag;
    assign hit_cnt          = r_hit_cnt;
    assign miss_cnt         = r_miss_cnt;

endmodule
`default_nettype wire
